game_stage_sequencer: RTL

Sequences the game-manager ROM through the fight script. It drives the ROM address and the `sync_game_manager` fetch handshake, and holds each entry for its `wait_time` in timer ticks. It ends the run on the terminator entry or on abort. It sits between the top-level game FSM (start/abort/pause) and the ROM reader, and publishes stage-boundary strobes to the attack and platform spawners.

---
 rtl/game_stage_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/game_stage_sequencer.sv
// game_stage_sequencer
// Steps the game-manager ROM through the fight script. Each entry is fetched
// over the sync/update handshake and then held for wait_time timer ticks. The
// run ends on the terminator entry, on a fetch timeout, on an address overrun
// or on abort.
//
// Handshake: sync_game_manager low requests the entry at addr; the reader
// raises update_game_manager with is_end/wait_time valid and holds them until
// sync_game_manager returns high. A transfer happens on the edge where the
// sequencer is in FETCH and update_game_manager is high.
//
// Build option SEQ_LOOP_EN: the terminator and an address overrun both wrap
// addr to 0 and keep fetching instead of finishing the run.
module game_stage_sequencer #(
    parameter int ADDR_WIDTH    = 8,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  tick,
    input  logic                  update_game_manager,
    input  logic                  is_end,
    input  logic [7:0]            wait_time,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  sync_game_manager,
    output logic                  stage_start,
    output logic                  stage_end,
    output logic                  busy,
    output logic                  done,
    output logic                  game_over,
    output logic                  fault,
    output logic [7:0]            wait_remaining,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_RUN     = 3'd2,
        S_ADVANCE = 3'd3,
        S_DONE    = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_wait;
    logic [7:0]            r_fetch_cnt;
    logic                  r_stage_start;
    logic                  r_stage_end;
    logic                  r_fault;

    logic                  w_restart;
    logic                  w_load;
    logic                  w_dec;
    logic                  w_end_pulse;
    logic                  w_addr_inc;
    logic                  w_addr_clr;
    logic                  w_set_fault;
`ifdef SEQ_LOOP_EN
    logic                  r_wrap;
    logic                  w_wrap;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control; abort wins over everything while busy
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_end_pulse  = 1'b0;
        w_addr_inc   = 1'b0;
        w_addr_clr   = 1'b0;
        w_set_fault  = 1'b0;
`ifdef SEQ_LOOP_EN
        w_wrap       = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_OVER: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_next_state = S_OVER;
                end else if (update_game_manager) begin
                    if (is_end) begin
`ifdef SEQ_LOOP_EN
                        // Pass through ADVANCE so sync goes high for a cycle
                        // and the reader drops the stale terminator.
                        w_wrap       = 1'b1;
                        w_next_state = S_ADVANCE;
`else
                        w_next_state = S_DONE;
`endif
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = S_RUN;
                    end
                end else if (r_fetch_cnt == TIMEOUT_LAST) begin
                    w_set_fault  = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next_state = S_OVER;
                end else if (r_wait == 8'd0) begin
                    w_end_pulse  = 1'b1;
                    w_next_state = S_ADVANCE;
                end else if (tick && !pause && !r_stage_start) begin
                    // A tick landing on the stage_start cycle is not counted
                    w_dec = 1'b1;
                end
            end
            S_ADVANCE: begin
                if (abort) begin
                    w_next_state = S_OVER;
                end else begin
`ifdef SEQ_LOOP_EN
                    // Overrun wraps naturally through the incrementer
                    w_addr_clr   = r_wrap;
                    w_addr_inc   = !r_wrap;
                    w_next_state = S_FETCH;
`else
                    if (r_addr == {ADDR_WIDTH{1'b1}}) begin
                        w_set_fault  = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_addr_inc   = 1'b1;
                        w_next_state = S_FETCH;
                    end
`endif
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers: address, countdown, fetch timer, strobes, fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_wait        <= 8'd0;
            r_fetch_cnt   <= 8'd0;
            r_stage_start <= 1'b0;
            r_stage_end   <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_stage_start <= w_load;
            r_stage_end   <= w_end_pulse;
            // Timer runs only while in FETCH, so it is zero on every entry
            r_fetch_cnt   <= (r_state == S_FETCH) ? r_fetch_cnt + 8'd1 : 8'd0;
            if (w_restart || w_addr_clr) begin
                r_addr <= '0;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_restart) begin
                r_fault <= 1'b0;
            end else if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (w_load) begin
                r_wait <= wait_time;
            end else if (w_dec) begin
                r_wait <= r_wait - 8'd1;
            end
        end
    end

`ifdef SEQ_LOOP_EN
    // Remembers that the current ADVANCE came from the terminator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else if (w_wrap) begin
            r_wrap <= 1'b1;
        end else if (r_state == S_ADVANCE) begin
            r_wrap <= 1'b0;
        end
    end
`endif

    assign addr              = r_addr;
    assign sync_game_manager = (r_state != S_FETCH);
    assign stage_start       = r_stage_start;
    assign stage_end         = r_stage_end;
    assign busy              = (r_state == S_FETCH) || (r_state == S_RUN) ||
                               (r_state == S_ADVANCE);
    assign done              = (r_state == S_DONE);
    assign game_over         = (r_state == S_OVER);
    assign fault             = r_fault;
    assign wait_remaining    = r_wait;
    assign dbg_state         = r_state;

endmodule
